// File: rtl/simon_pkt_in_gen.sv
// simon_pkt_in_gen: packet input unit for the SIMON core (multi-packet key assembly, block FIFO).
// Optional define SIMON_SEQ_CHECK_EN adds the count-byte sequence checker driving seqErr.

module simon_pkt_in_gen #(
  parameter int N  = 16,
  parameter int M  = 4,
  parameter int PB = 8,
  parameter int D  = 4
) (
  input  logic                clk,
  input  logic                R,
  input  logic [(PB+2)*8-1:0] in,
  input  logic                newPkt,
  output logic                loadPkt,
  output logic                donePkt,
  output logic [7:0]          infoIN,
  output logic [7:0]          countIN,
  output logic                newKey,
  input  logic                loadKey,
  output logic [M*N-1:0]      KEY,
  output logic                newData,
  input  logic                loadData,
  output logic [2*N-1:0]      blockIN,
  output logic                seqErr
);

  localparam int BW      = 2 * N;
  localparam int PW      = PB * 8;
  localparam int BPP     = PW / BW;
  localparam int KP      = (M * N) / PW;
  localparam int AW      = (D > 1) ? $clog2(D) : 1;
  localparam int BIW     = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int SHW     = (KP > 1) ? $clog2(KP) : 1;
  localparam int MAX_OCC = D - BPP;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPT,
    S_UNPACK,
    S_KEYW,
    S_DONE
  } state_e;

  typedef logic [BPP-1:0][BW-1:0] blocks_t;
  typedef logic [KP-1:0][PW-1:0]  shards_t;

  state_e          state_q, state_d;
  logic [PW-1:0]   pkt_q, pkt_d;
  logic            is_key_q, is_key_d;
  logic            valid_q, valid_d;
  logic [7:0]      info_q, info_d;
  logic [7:0]      count_q, count_d;
  logic            load_pkt_q, load_pkt_d;
  logic            done_pkt_q, done_pkt_d;
  shards_t         key_q, key_d;
  logic            new_key_q, new_key_d;
  logic [SHW-1:0]  shard_q, shard_d;
  logic [BIW-1:0]  blk_q, blk_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic            new_data_q, new_data_d;
  logic            ld_data_q, ld_data_d;

  logic [BW-1:0]   mem_q [D];
  blocks_t         pkt_blocks;
  logic            wr_en;
  logic            pop;
  logic            admit;

  logic [7:0]      in_info;
  logic [7:0]      in_count;
  logic [PW-1:0]   in_payload;

`ifdef SIMON_SEQ_CHECK_EN
  logic [7:0]      exp_q, exp_d;
  logic            seq_err_q, seq_err_d;
`endif

  assign in_info    = in[PW+15:PW+8];
  assign in_count   = in[PW+7:PW];
  assign in_payload = in[PW-1:0];
  assign pkt_blocks = pkt_q;

  // A malformed packet is always taken so the link cannot stall on garbage.
  always_comb begin
    admit = 1'b0;
    if (!in_info[7])     admit = 1'b1;
    else if (in_info[5]) admit = !new_key_q;
    else                 admit = (occ_q <= (AW+1)'(MAX_OCC));
  end

  assign pop = loadData && !ld_data_q && new_data_q;

  always_comb begin
    // NOTE: every _d takes its _q value first, so branches that skip a signal cannot infer a latch.
    state_d    = state_q;
    pkt_d      = pkt_q;
    is_key_d   = is_key_q;
    valid_d    = valid_q;
    info_d     = info_q;
    count_d    = count_q;
    load_pkt_d = 1'b0;
    done_pkt_d = 1'b0;
    key_d      = key_q;
    new_key_d  = new_key_q && !loadKey;
    shard_d    = shard_q;
    blk_d      = blk_q;
    wr_en      = 1'b0;
`ifdef SIMON_SEQ_CHECK_EN
    exp_d      = exp_q;
    seq_err_d  = seq_err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (newPkt && admit) begin
          pkt_d      = in_payload;
          info_d     = in_info;
          count_d    = in_count;
          is_key_d   = in_info[5];
          valid_d    = in_info[7];
          load_pkt_d = 1'b1;
          state_d    = S_CAPT;
`ifdef SIMON_SEQ_CHECK_EN
          if (in_info[7]) begin
            if (in_count != exp_q) seq_err_d = 1'b1;
            exp_d = in_count + 8'd1;
          end
`endif
        end
      end
      S_CAPT: begin
        blk_d = '0;
        if (!valid_q)     state_d = S_DONE;
        else if (is_key_q) state_d = S_KEYW;
        else              state_d = S_UNPACK;
      end
      S_UNPACK: begin
        wr_en = 1'b1;
        if (blk_q == BIW'(BPP - 1)) state_d = S_DONE;
        else                        blk_d   = blk_q + 1'b1;
      end
      S_KEYW: begin
        key_d[shard_q] = pkt_q;
        if (shard_q == SHW'(KP - 1)) begin
          new_key_d = 1'b1;
          shard_d   = '0;
        end else begin
          shard_d = shard_q + 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done_pkt_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write and pop in the same cycle leave occupancy unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    occ_d    = occ_q;
    unique case ({wr_en, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    new_data_d = (occ_d != '0);
    ld_data_d  = loadData;
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q    <= S_IDLE;
      pkt_q      <= '0;
      is_key_q   <= 1'b0;
      valid_q    <= 1'b0;
      info_q     <= '0;
      count_q    <= '0;
      load_pkt_q <= 1'b0;
      done_pkt_q <= 1'b0;
      key_q      <= '0;
      new_key_q  <= 1'b0;
      shard_q    <= '0;
      blk_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      new_data_q <= 1'b0;
      ld_data_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the same pre-edge values.
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      is_key_q   <= is_key_d;
      valid_q    <= valid_d;
      info_q     <= info_d;
      count_q    <= count_d;
      load_pkt_q <= load_pkt_d;
      done_pkt_q <= done_pkt_d;
      key_q      <= key_d;
      new_key_q  <= new_key_d;
      shard_q    <= shard_d;
      blk_q      <= blk_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      new_data_q <= new_data_d;
      ld_data_q  <= ld_data_d;
    end
  end

  // NOTE: FIFO storage has no reset; occupancy gates blockIN, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= pkt_blocks[blk_q];
  end

`ifdef SIMON_SEQ_CHECK_EN
  always_ff @(posedge clk) begin
    if (R) begin
      exp_q     <= '0;
      seq_err_q <= 1'b0;
    end else begin
      exp_q     <= exp_d;
      seq_err_q <= seq_err_d;
    end
  end
  assign seqErr = seq_err_q;
`else
  assign seqErr = 1'b0;
`endif

  assign loadPkt = load_pkt_q;
  assign donePkt = done_pkt_q;
  assign infoIN  = info_q;
  assign countIN = count_q;
  assign newKey  = new_key_q;
  assign KEY     = key_q;
  assign newData = new_data_q;
  assign blockIN = new_data_q ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_simon_pkt_in_gen.sv
// Self-checking bench for simon_pkt_in_gen: directed cases then randomized packets vs a
// transaction-level model (block queue, key shards, count tracker).

module tb_simon_pkt_in_gen;

  localparam int N   = 16;
  localparam int M   = 4;
  localparam int PB  = 8;
  localparam int D   = 4;
  localparam int BW  = 2 * N;
  localparam int PW  = PB * 8;
  localparam int BPP = PW / BW;
  localparam int KP  = (M * N) / PW;

  logic                clk = 1'b0;
  logic                R = 1'b1;
  logic [(PB+2)*8-1:0] pkt_in = '0;
  logic                newPkt = 1'b0;
  logic                loadPkt, donePkt;
  logic [7:0]          infoIN, countIN;
  logic                newKey;
  logic                loadKey = 1'b0;
  logic [M*N-1:0]      KEY;
  logic                newData;
  logic                loadData = 1'b0;
  logic [BW-1:0]       blockIN;
  logic                seqErr;

  simon_pkt_in_gen #(.N(N), .M(M), .PB(PB), .D(D)) dut (
    .clk(clk), .R(R), .in(pkt_in), .newPkt(newPkt), .loadPkt(loadPkt), .donePkt(donePkt),
    .infoIN(infoIN), .countIN(countIN), .newKey(newKey), .loadKey(loadKey), .KEY(KEY),
    .newData(newData), .loadData(loadData), .blockIN(blockIN), .seqErr(seqErr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [BW-1:0]  mq[$];
  logic [M*N-1:0] m_key;
  bit             m_new_key;
  int             m_shard;
  bit             m_seq_err;
  logic [7:0]     m_exp;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_seq_err();
`ifdef SIMON_SEQ_CHECK_EN
    return m_seq_err;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_key     = '0;
    m_new_key = 1'b0;
    m_shard   = 0;
    m_seq_err = 1'b0;
    m_exp     = 8'd0;
  endtask

  task automatic check_state(input string tag);
    logic [BW-1:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    check({tag, ":newData"}, newData, mq.size() != 0);
    check({tag, ":blockIN"}, blockIN, head);
    check({tag, ":newKey"},  newKey,  m_new_key);
    check({tag, ":KEY"},     KEY,     m_key);
    check({tag, ":seqErr"},  seqErr,  exp_seq_err());
  endtask

  task automatic do_reset();
    R = 1'b1;
    step();
    R = 1'b0;
    model_reset();
    check("rst:loadPkt", loadPkt, 0);
    check("rst:donePkt", donePkt, 0);
    check("rst:infoIN",  infoIN,  0);
    check("rst:countIN", countIN, 0);
    check_state("rst");
  endtask

  // Offers one packet; expects capture exactly when the model says it is admissible.
  task automatic send_pkt(input logic [7:0] info, input logic [7:0] cnt,
                          input logic [PW-1:0] pay, input bit pop_mid);
    bit adm, got, done;
    int lat, exp_lat;
    adm = !info[7] || (info[5] ? !m_new_key : ((D - mq.size()) >= BPP));
    pkt_in = {info, cnt, pay};
    newPkt = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (loadPkt) begin
        got = 1'b1;
        break;
      end
    end
    newPkt = 1'b0;
    check("capture", got, adm);
    if (!got) begin
      step();
      return;
    end
    check("infoIN", infoIN, info);
    check("countIN", countIN, cnt);
    if (info[7]) begin
      if (cnt != m_exp) m_seq_err = 1'b1;
      m_exp = cnt + 8'd1;
    end
    done = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) begin
        check("loadPkt_pulse", loadPkt, 0);
        if (pop_mid) loadData = 1'b1;
      end
      if (i == 2 && pop_mid) begin
        loadData = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
      end
      if (donePkt) begin
        done = 1'b1;
        lat  = i;
        break;
      end
    end
    exp_lat = !info[7] ? 2 : (info[5] ? 3 : BPP + 2);
    check("done_seen", done, 1);
    check("done_lat", lat, exp_lat);
    if (info[7] && info[5]) begin
      m_key[m_shard*PW +: PW] = pay;
      m_shard++;
      if (m_shard == KP) begin
        m_new_key = 1'b1;
        m_shard   = 0;
      end
    end else if (info[7]) begin
      for (int b = 0; b < BPP; b++) mq.push_back(pay[b*BW +: BW]);
    end
    step();
    check("donePkt_pulse", donePkt, 0);
    check_state("pkt");
  endtask

  task automatic pop(input int hold);
    bit will;
    will = (mq.size() != 0);
    loadData = 1'b1;
    repeat (hold) step();
    loadData = 1'b0;
    step();
    if (will) void'(mq.pop_front());
    check_state("pop");
  endtask

  task automatic ack_key();
    loadKey = 1'b1;
    step();
    loadKey = 1'b0;
    m_new_key = 1'b0;
    check_state("ack");
  endtask

  task automatic reset_mid_unpack(input logic [PW-1:0] pay);
    bit got, seen;
    pkt_in = {8'h80, m_exp, pay};
    newPkt = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (loadPkt) begin
        got = 1'b1;
        break;
      end
    end
    newPkt = 1'b0;
    check("rmid:capture", got, 1);
    step();
    step();
    check("rmid:first_block", newData, 1);
    R = 1'b1;
    step();
    R = 1'b0;
    model_reset();
    check("rmid:newData", newData, 0);
    seen = 1'b0;
    repeat (6) begin
      step();
      if (donePkt) seen = 1'b1;
    end
    check("rmid:no_done", seen, 0);
    check_state("rmid");
    send_pkt(8'h80, m_exp, pay, 1'b0);
  endtask

  initial begin
    logic [7:0]    info, cnt;
    logic [PW-1:0] pay;
    int            r;

    model_reset();
    step();
    do_reset();

    // Single key packet then acknowledge.
    send_pkt(8'hA0, 8'h00, 64'h1918111009080100, 1'b0);
    check("tp:key", KEY, 64'h1918111009080100);
    check("tp:newKey", newKey, 1);
    ack_key();

    // Data packet and held-loadData single pop.
    send_pkt(8'h80, 8'h01, 64'h6565687721403F21, 1'b0);
    check("tp:block0", blockIN, 32'h21403F21);
    pop(2);
    check("tp:block1", blockIN, 32'h65656877);
    pop(1);
    check("tp:empty", newData, 0);
    pop(1);

    // FIFO admission: third packet waits until two slots free.
    send_pkt(8'h80, m_exp, {$urandom(), $urandom()}, 1'b0);
    send_pkt(8'h80, m_exp, {$urandom(), $urandom()}, 1'b0);
    send_pkt(8'h80, m_exp, {$urandom(), $urandom()}, 1'b0);
    pop(1);
    pop(1);
    send_pkt(8'h80, m_exp, {$urandom(), $urandom()}, 1'b0);
    repeat (4) pop(1);

    // Write and pop in the same cycle.
    send_pkt(8'h80, m_exp, {$urandom(), $urandom()}, 1'b0);
    send_pkt(8'h80, m_exp, {$urandom(), $urandom()}, 1'b1);
    repeat (4) pop(1);

    // Malformed packet is captured and dropped; second key blocked while newKey.
    send_pkt(8'h20, 8'h33, {$urandom(), $urandom()}, 1'b0);
    send_pkt(8'hA0, m_exp, {$urandom(), $urandom()}, 1'b0);
    send_pkt(8'hA0, m_exp, {$urandom(), $urandom()}, 1'b0);
    ack_key();

    // Sequence break, then resync.
    send_pkt(8'h80, m_exp + 8'd4, {$urandom(), $urandom()}, 1'b0);
`ifdef SIMON_SEQ_CHECK_EN
    check("tp:seqErr_set", seqErr, 1);
`else
    check("tp:seqErr_off", seqErr, 0);
`endif
    send_pkt(8'h80, m_exp, {$urandom(), $urandom()}, 1'b0);
    repeat (4) pop(1);

    do_reset();
    reset_mid_unpack(64'hDEADBEEF01234567);
    repeat (2) pop(1);

    for (int it = 0; it < 250; it++) begin
      r   = $urandom_range(0, 99);
      cnt = ($urandom_range(0, 9) == 0) ? 8'($urandom()) : m_exp;
      pay = {$urandom(), $urandom()};
      if (r < 35) begin
        info = (8'($urandom()) & 8'h5F) | 8'h80;
        send_pkt(info, cnt, pay, ($urandom_range(0, 3) == 0) && (mq.size() != 0));
      end else if (r < 50) begin
        info = (8'($urandom()) & 8'h7F) | 8'hA0;
        send_pkt(info, cnt, pay, 1'b0);
      end else if (r < 75) begin
        pop($urandom_range(1, 3));
      end else if (r < 88) begin
        ack_key();
      end else if (r < 97) begin
        info = 8'($urandom()) & 8'h7F;
        send_pkt(info, cnt, pay, 1'b0);
      end else begin
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
